// File: rtl/ras_stack_if.sv
// Return address stack port bundle: push/pop/restore requests from the
// fetch predictor and the top-of-stack / pointer exports back to it.
interface ras_stack_if #(
  parameter int LOG_RAS_ENTRIES = 4,
  parameter int PC_W            = 38
);
  logic                       push_valid;
  logic [PC_W-1:0]            push_pc38;
  logic                       pop_valid;
  logic                       ret_valid;
  logic [PC_W-1:0]            ret_pc38;
  logic [LOG_RAS_ENTRIES-1:0] ras_index;
  logic [LOG_RAS_ENTRIES:0]   ras_count;
  logic                       restore_valid;
  logic [LOG_RAS_ENTRIES-1:0] restore_ras_index;
  logic [LOG_RAS_ENTRIES:0]   restore_ras_count;

  // Fetch predictor side: issues requests, consumes the stack top.
  modport master (
    output push_valid, push_pc38, pop_valid,
    output restore_valid, restore_ras_index, restore_ras_count,
    input  ret_valid, ret_pc38, ras_index, ras_count
  );

  // Stack side: accepts requests, exports the stack top and pointers.
  modport slave (
    input  push_valid, push_pc38, pop_valid,
    input  restore_valid, restore_ras_index, restore_ras_count,
    output ret_valid, ret_pc38, ras_index, ras_count
  );
endinterface

// File: rtl/ras_stack.sv
// Circular return address stack for the fetch predictor. Pushes fall-through
// PCs on calls, supplies the top entry combinationally for return redirects,
// and exports/accepts {index, count} for branch checkpoint restore.
module ras_stack #(
  parameter int          RAS_ENTRIES     = 16,
  parameter int          LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES),
  parameter logic [37:0] INIT_RET_PC38   = 38'h0
) (
  input logic          clk,
  input logic          rst_n,
  ras_stack_if.slave   bus
);

  typedef logic [LOG_RAS_ENTRIES-1:0] ras_idx_t;
  typedef logic [LOG_RAS_ENTRIES:0]   ras_cnt_t;
  typedef logic [37:0]                pc38_t;

  localparam ras_cnt_t CNT_MAX = ras_cnt_t'(RAS_ENTRIES);
  localparam ras_idx_t IDX_ONE = ras_idx_t'(1);
  localparam ras_cnt_t CNT_ONE = ras_cnt_t'(1);

  pc38_t    stack_q [RAS_ENTRIES];
  ras_idx_t index_q, index_d;
  ras_cnt_t count_q, count_d;

  logic     wr_en;
  ras_idx_t wr_idx;

  // Next pointer/count and the single entry write, in priority order:
  // restore, push, pop, push+pop (replace top), hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    index_d = index_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = index_q;

    if (bus.restore_valid) begin
      index_d = bus.restore_ras_index;
      count_d = (bus.restore_ras_count > CNT_MAX) ? CNT_MAX : bus.restore_ras_count;
    end else if (bus.push_valid && !bus.pop_valid) begin
      // Index wraps modulo the depth, so a push when full overwrites the oldest entry.
      index_d = index_q + IDX_ONE;
      wr_en   = 1'b1;
      wr_idx  = index_q + IDX_ONE;
      count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
    end else if (bus.pop_valid && !bus.push_valid) begin
      // Popping an empty stack still moves the pointer; only the count saturates.
      index_d = index_q - IDX_ONE;
      count_d = (count_q == '0) ? '0 : count_q - CNT_ONE;
    end else if (bus.pop_valid && bus.push_valid) begin
      wr_en   = 1'b1;
      count_d = (count_q == '0) ? CNT_ONE : count_q;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      index_q <= '0;
      count_q <= '0;
    end else begin
      index_q <= index_d;
      count_q <= count_d;
    end
  end

  // Flop-based stack storage with one write port.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this storage is deliberately reset, since a return taken before any
    // push must read a known address; that rules out mapping it to an SRAM.
    if (!rst_n) begin
      for (int i = 0; i < RAS_ENTRIES; i++) stack_q[i] <= INIT_RET_PC38;
    end else if (wr_en) begin
      stack_q[wr_idx] <= bus.push_pc38;
    end
  end

  // Zero-latency read of the top; the data is not qualified by ret_valid.
  assign bus.ret_pc38  = stack_q[index_q];
  assign bus.ret_valid = (count_q != '0);
  assign bus.ras_index = index_q;
  assign bus.ras_count = count_q;

endmodule

// File: tb/tb_ras_stack.sv
// Self-checking bench for ras_stack: directed boundary cases followed by a
// randomized mix of push/pop/restore, compared against an array-based model.
module tb_ras_stack;

  logic clk;
  logic rst_n;

  ras_stack_if u_if ();

  ras_stack u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a plain array plus integer pointer and live count.
  logic [37:0] m_stack [16];
  int          m_idx;
  int          m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_stack[i] = 38'h0;
    m_idx = 0;
    m_cnt = 0;
  endtask

  // Apply one clock edge's worth of the stack rules to the model.
  task automatic model_step(input logic push, input logic [37:0] pc, input logic pop,
                            input logic rv, input int ri, input int rc);
    if (rv) begin
      m_idx = ri;
      m_cnt = (rc > 16) ? 16 : rc;
    end else if (push && pop) begin
      m_stack[m_idx] = pc;
      if (m_cnt == 0) m_cnt = 1;
    end else if (push) begin
      m_idx = (m_idx + 1) % 16;
      m_stack[m_idx] = pc;
      if (m_cnt < 16) m_cnt++;
    end else if (pop) begin
      m_idx = (m_idx + 15) % 16;
      if (m_cnt > 0) m_cnt--;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".index"}, 64'(u_if.ras_index), 64'(m_idx));
    check({tag, ".count"}, 64'(u_if.ras_count), 64'(m_cnt));
    check({tag, ".valid"}, 64'(u_if.ret_valid), 64'(m_cnt != 0));
    check({tag, ".pc"},    64'(u_if.ret_pc38),  64'(m_stack[m_idx]));
  endtask

  task automatic drive(input logic push, input logic [37:0] pc, input logic pop,
                       input logic rv, input int ri, input int rc);
    u_if.push_valid        = push;
    u_if.push_pc38         = pc;
    u_if.pop_valid         = pop;
    u_if.restore_valid     = rv;
    u_if.restore_ras_index = 4'(ri);
    u_if.restore_ras_count = 5'(rc);
  endtask

  // One clock: the model consumes the inputs held across the edge, then the
  // outputs are compared 1 time unit after the edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    #1;
    model_step(u_if.push_valid, u_if.push_pc38, u_if.pop_valid, u_if.restore_valid,
               int'(u_if.restore_ras_index), int'(u_if.restore_ras_count));
    check_model(tag);
  endtask

  task automatic do_reset();
    drive(1'b0, 38'h0, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_model("reset");
    check("reset.pc_const", 64'(u_if.ret_pc38), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;

    // Reset state.
    do_reset();

    // Push A, push B, pop.
    drive(1'b1, 38'h100, 1'b0, 1'b0, 0, 0); cycle("pushA");
    drive(1'b1, 38'h200, 1'b0, 1'b0, 0, 0); cycle("pushB");
    check("pushB.index_const", 64'(u_if.ras_index), 64'd2);
    check("pushB.pc_const",    64'(u_if.ret_pc38),  64'h200);
    drive(1'b0, 38'h0, 1'b1, 1'b0, 0, 0);   cycle("popB");
    check("popB.pc_const",     64'(u_if.ret_pc38),  64'h100);
    check("popB.count_const",  64'(u_if.ras_count), 64'd1);

    // Overflow by one, drain fully, then underflow.
    do_reset();
    for (int v = 1; v <= 17; v++) begin
      drive(1'b1, 38'(v), 1'b0, 1'b0, 0, 0); cycle("fill");
    end
    check("full.count_const", 64'(u_if.ras_count), 64'd16);
    check("full.index_const", 64'(u_if.ras_index), 64'd1);
    check("full.pc_const",    64'(u_if.ret_pc38),  64'd17);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 38'h0, 1'b1, 1'b0, 0, 0); cycle("drain");
    end
    check("drained.count_const", 64'(u_if.ras_count), 64'd0);
    drive(1'b0, 38'h0, 1'b1, 1'b0, 0, 0); cycle("underflow");
    check("underflow.index_const", 64'(u_if.ras_index), 64'd0);
    check("underflow.valid_const", 64'(u_if.ret_valid), 64'd0);
    drive(1'b0, 38'h0, 1'b1, 1'b0, 0, 0); cycle("underflow_wrap");
    check("underflow_wrap.index_const", 64'(u_if.ras_index), 64'd15);

    // Replace the top with simultaneous push and pop.
    do_reset();
    drive(1'b1, 38'h100, 1'b0, 1'b0, 0, 0); cycle("rep_push1");
    drive(1'b1, 38'h200, 1'b0, 1'b0, 0, 0); cycle("rep_push2");
    drive(1'b1, 38'h300, 1'b0, 1'b0, 0, 0); cycle("rep_push3");
    drive(1'b1, 38'h3F0, 1'b1, 1'b0, 0, 0); cycle("replace");
    check("replace.pc_const",    64'(u_if.ret_pc38),  64'h3F0);
    check("replace.index_const", 64'(u_if.ras_index), 64'd3);
    drive(1'b0, 38'h0, 1'b1, 1'b0, 0, 0);   cycle("replace_pop");
    check("replace_pop.below_const", 64'(u_if.ret_pc38), 64'h200);

    // Restore wins over a push; over-range count is clamped.
    drive(1'b1, 38'hABC, 1'b0, 1'b1, 5, 2); cycle("restore");
    check("restore.index_const", 64'(u_if.ras_index), 64'd5);
    check("restore.count_const", 64'(u_if.ras_count), 64'd2);
    drive(1'b0, 38'h0, 1'b0, 1'b1, 3, 3);   cycle("restore_back");
    check("restore_back.pc_const", 64'(u_if.ret_pc38), 64'h3F0);
    drive(1'b0, 38'h0, 1'b0, 1'b1, 2, 2);   cycle("restore_below");
    check("restore_below.pc_const", 64'(u_if.ret_pc38), 64'h200);
    drive(1'b0, 38'h0, 1'b0, 1'b1, 7, 31);  cycle("restore_clamp");
    check("restore_clamp.count_const", 64'(u_if.ras_count), 64'd16);
    drive(1'b0, 38'h0, 1'b0, 1'b0, 0, 0);   cycle("hold");

    // Asynchronous reset while a push is pending.
    do_reset();
    drive(1'b1, 38'h111, 1'b0, 1'b0, 0, 0); cycle("pre_rst_push");
    drive(1'b1, 38'h222, 1'b0, 1'b0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    @(posedge clk);
    #1;
    check_model("rst_held");
    #2;
    rst_n = 1'b1;
    drive(1'b0, 38'h0, 1'b0, 1'b0, 0, 0);
    cycle("post_rst");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] r;
      logic        rv;
      r  = {$urandom(), $urandom()};
      rv = ($urandom_range(0, 15) == 0);
      drive(1'($urandom_range(0, 1)), r[37:0], 1'($urandom_range(0, 1)), rv,
            int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
